// File: rtl/mux_n_to_1_reg.sv
// Registered N-to-1 mux stage with valid/ready handshake and a two-entry skid buffer.
// Define MUX_SEL_ERR_CNT_EN to add the saturating bad-select counter on Err_Count.
module mux_n_to_1_reg #(
    parameter int WIDTH    = 32,
    parameter int N_INPUTS = 5,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_INPUTS*WIDTH-1:0] I,
    input  logic [SEL_W-1:0]          Select,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          O,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      Sel_Err
`ifdef MUX_SEL_ERR_CNT_EN
    ,
    output logic [7:0]                Err_Count
`endif
);

    logic [WIDTH-1:0] outData_q, outData_d;
    logic             outErr_q, outErr_d;
    logic             outValid_q, outValid_d;
    logic [WIDTH-1:0] skidData_q, skidData_d;
    logic             skidErr_q, skidErr_d;
    logic             skidValid_q, skidValid_d;

    logic [WIDTH-1:0] newData;
    logic             newErr;
    logic             accept;
    logic             drain;

    // Out-of-range selects fall through the loop untouched: zero data, error set.
    always_comb begin
        newData = '0;
        newErr  = 1'b1;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (Select == SEL_W'(k)) begin
                newData = I[k*WIDTH +: WIDTH];
                newErr  = 1'b0;
            end
        end
    end

    assign in_ready = !skidValid_q && !reset;
    assign accept   = in_valid && in_ready;
    assign drain    = outValid_q && out_ready;

    always_comb begin
        outData_d   = outData_q;
        outErr_d    = outErr_q;
        outValid_d  = outValid_q;
        skidData_d  = skidData_q;
        skidErr_d   = skidErr_q;
        skidValid_d = skidValid_q;

        if (!outValid_q || drain) begin
            if (skidValid_q) begin
                outData_d   = skidData_q;
                outErr_d    = skidErr_q;
                outValid_d  = 1'b1;
                skidValid_d = 1'b0;
                if (accept) begin
                    skidData_d  = newData;
                    skidErr_d   = newErr;
                    skidValid_d = 1'b1;
                end
            end else if (accept) begin
                outData_d  = newData;
                outErr_d   = newErr;
                outValid_d = 1'b1;
            end else begin
                outValid_d = 1'b0;
            end
        end else if (accept) begin
            skidData_d  = newData;
            skidErr_d   = newErr;
            skidValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outData_q   <= '0;
            outErr_q    <= 1'b0;
            outValid_q  <= 1'b0;
            skidData_q  <= '0;
            skidErr_q   <= 1'b0;
            skidValid_q <= 1'b0;
        end else begin
            outData_q   <= outData_d;
            outErr_q    <= outErr_d;
            outValid_q  <= outValid_d;
            skidData_q  <= skidData_d;
            skidErr_q   <= skidErr_d;
            skidValid_q <= skidValid_d;
        end
    end

    assign O         = outData_q;
    assign Sel_Err   = outErr_q;
    assign out_valid = outValid_q;

`ifdef MUX_SEL_ERR_CNT_EN
    logic [7:0] errCount_q, errCount_d;

    // Counts at acceptance time, so a stalled bad beat is counted exactly once.
    always_comb begin
        errCount_d = errCount_q;
        if (accept && newErr && (errCount_q != 8'hFF)) begin
            errCount_d = errCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            errCount_q <= 8'd0;
        end else begin
            errCount_q <= errCount_d;
        end
    end

    assign Err_Count = errCount_q;
`endif

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Bench for mux_n_to_1_reg: default instance (32b x 5) plus an 8b x 16 instance,
// both checked every cycle against a queue-based model of the stage contents.
module tb_mux_n_to_1_reg;

    logic         clk;
    logic         reset;

    logic [159:0] iA;
    logic [2:0]   selA;
    logic         inValidA, inReadyA, outValidA, outReadyA, selErrA;
    logic [31:0]  oA;

    logic [127:0] iB;
    logic [3:0]   selB;
    logic         inValidB, inReadyB, outValidB, outReadyB, selErrB;
    logic [7:0]   oB;

`ifdef MUX_SEL_ERR_CNT_EN
    logic [7:0]   errCountA, errCountB;
`endif

    int checks    = 0;
    int failures  = 0;
    bit armed     = 0;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } beat_t;

    beat_t qA[$];
    beat_t qB[$];
    int errCntA   = 0;
    int errCntB   = 0;
    int acceptedB = 0;

    mux_n_to_1_reg dutA (
        .clk       (clk),
        .reset     (reset),
        .I         (iA),
        .Select    (selA),
        .in_valid  (inValidA),
        .in_ready  (inReadyA),
        .O         (oA),
        .out_valid (outValidA),
        .out_ready (outReadyA),
        .Sel_Err   (selErrA)
`ifdef MUX_SEL_ERR_CNT_EN
        ,
        .Err_Count (errCountA)
`endif
    );

    mux_n_to_1_reg #(.WIDTH(8), .N_INPUTS(16), .SEL_W(4)) dutB (
        .clk       (clk),
        .reset     (reset),
        .I         (iB),
        .Select    (selB),
        .in_valid  (inValidB),
        .in_ready  (inReadyB),
        .O         (oB),
        .out_valid (outValidB),
        .out_ready (outReadyB),
        .Sel_Err   (selErrB)
`ifdef MUX_SEL_ERR_CNT_EN
        ,
        .Err_Count (errCountB)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The stage is a FIFO of at most two beats; it accepts whenever fewer than two are held.
    task automatic modelStep();
        beat_t nb;
        bit    accA, accB;
        if (reset) begin
            qA.delete();
            qB.delete();
            errCntA = 0;
            errCntB = 0;
            return;
        end
        accA = inValidA && (qA.size() < 2);
        accB = inValidB && (qB.size() < 2);
        if (qA.size() > 0 && outReadyA) void'(qA.pop_front());
        if (qB.size() > 0 && outReadyB) void'(qB.pop_front());
        if (accA) begin
            if (int'(selA) < 5) begin
                nb.err  = 1'b0;
                nb.data = iA[int'(selA)*32 +: 32];
            end else begin
                nb.err  = 1'b1;
                nb.data = 32'd0;
            end
            qA.push_back(nb);
            if (nb.err && errCntA < 255) errCntA++;
        end
        if (accB) begin
            if (int'(selB) < 16) begin
                nb.err  = 1'b0;
                nb.data = {24'd0, iB[int'(selB)*8 +: 8]};
            end else begin
                nb.err  = 1'b1;
                nb.data = 32'd0;
            end
            qB.push_back(nb);
            acceptedB++;
            if (nb.err && errCntB < 255) errCntB++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            checkOutput("inReadyA", inReadyA, !reset && (qA.size() < 2));
            checkOutput("outValidA", outValidA, qA.size() > 0);
            if (qA.size() > 0) begin
                checkOutput("dataA", oA, qA[0].data);
                checkOutput("selErrA", selErrA, qA[0].err);
            end
            checkOutput("inReadyB", inReadyB, !reset && (qB.size() < 2));
            checkOutput("outValidB", outValidB, qB.size() > 0);
            if (qB.size() > 0) begin
                checkOutput("dataB", oB, qB[0].data);
                checkOutput("selErrB", selErrB, qB[0].err);
            end
`ifdef MUX_SEL_ERR_CNT_EN
            checkOutput("errCountA", errCountA, errCntA);
            checkOutput("errCountB", errCountB, errCntB);
`endif
        end
    end

    task automatic applyStimulus(input logic vld, input logic [2:0] sel, input logic rdy);
        inValidA  = vld;
        selA      = sel;
        outReadyA = rdy;
        tick();
    endtask

    initial begin
        int cyc;
        reset     = 1'b1;
        inValidA  = 1'b1;
        selA      = 3'd0;
        outReadyA = 1'b1;
        inValidB  = 1'b0;
        selB      = 4'd0;
        outReadyB = 1'b1;
        iB        = '0;
        for (int k = 0; k < 5; k++) iA[k*32 +: 32] = 32'h1000 + k;

        // Reset held two cycles with a beat offered
        tick();
        armed = 1'b1;
        tick();
        checkOutput("rst_outValid", outValidA, 1'b0);
        checkOutput("rst_O", oA, 32'd0);
        checkOutput("rst_inReady", inReadyA, 1'b0);
        reset    = 1'b0;
        inValidA = 1'b0;
        #1;
        checkOutput("rel_inReady", inReadyA, 1'b1);

        // Back-to-back streaming
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 3'(k), 1'b1);
            checkOutput("stream_O", oA, 32'h1000 + k);
            checkOutput("stream_valid", outValidA, 1'b1);
        end
        applyStimulus(1'b0, 3'd0, 1'b1);
        checkOutput("stream_empty", outValidA, 1'b0);

        // Backpressure into the skid entry
        iA[0 +: 32]  = 32'hA;
        iA[32 +: 32] = 32'hB;
        iA[64 +: 32] = 32'hC;
        applyStimulus(1'b1, 3'd0, 1'b0);
        checkOutput("bp_O_a", oA, 32'hA);
        checkOutput("bp_ready_a", inReadyA, 1'b1);
        applyStimulus(1'b1, 3'd1, 1'b0);
        checkOutput("bp_O_b", oA, 32'hA);
        checkOutput("bp_ready_b", inReadyA, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0);
        checkOutput("bp_hold_O", oA, 32'hA);
        checkOutput("bp_hold_ready", inReadyA, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b1);
        checkOutput("bp_drain_B", oA, 32'hB);
        checkOutput("bp_drain_ready", inReadyA, 1'b1);
        applyStimulus(1'b1, 3'd2, 1'b1);
        checkOutput("bp_drain_C", oA, 32'hC);
        applyStimulus(1'b0, 3'd0, 1'b1);
        checkOutput("bp_empty", outValidA, 1'b0);

        // Out-of-range selects
        for (int k = 5; k < 8; k++) begin
            applyStimulus(1'b1, 3'(k), 1'b1);
            checkOutput("bad_O", oA, 32'd0);
            checkOutput("bad_err", selErrA, 1'b1);
        end
`ifdef MUX_SEL_ERR_CNT_EN
        checkOutput("bad_count3", errCountA, 8'd3);
`endif
        for (int k = 0; k < 300; k++) applyStimulus(1'b1, 3'(5 + (k % 3)), 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b1);
`ifdef MUX_SEL_ERR_CNT_EN
        checkOutput("bad_count_sat", errCountA, 8'd255);
`endif

        // Reset while both entries are full
        applyStimulus(1'b1, 3'd3, 1'b0);
        applyStimulus(1'b1, 3'd4, 1'b0);
        checkOutput("stall_ready", inReadyA, 1'b0);
        reset    = 1'b1;
        inValidA = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", outValidA, 1'b0);
        checkOutput("mid_rst_ready", inReadyA, 1'b1);
`ifdef MUX_SEL_ERR_CNT_EN
        checkOutput("mid_rst_count", errCountA, 8'd0);
`endif

        // Random traffic on the default instance, with occasional resets
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < 5; k++) iA[k*32 +: 32] = $urandom;
            reset     = ($urandom_range(0, 199) == 0);
            inValidA  = $urandom_range(0, 1) == 1;
            selA      = 3'($urandom_range(0, 7));
            outReadyA = $urandom_range(0, 3) != 0;
            tick();
        end
        reset     = 1'b0;
        inValidA  = 1'b0;
        outReadyA = 1'b1;

        // Random traffic on the wide-select instance until 10k beats are accepted
        cyc = 0;
        while (acceptedB < 10000 && cyc < 40000) begin
            iB        = {$urandom, $urandom, $urandom, $urandom};
            inValidB  = $urandom_range(0, 3) != 0;
            selB      = 4'($urandom_range(0, 15));
            outReadyB = $urandom_range(0, 3) != 0;
            tick();
            cyc++;
        end
        checkOutput("beatsB_done", acceptedB >= 10000, 1'b1);
        inValidB = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
